// File: rtl/btn_debounce_multi.sv
// Multi-channel button synchroniser and symmetric debouncer with one-cycle press/release strobes.
// Optional auto-repeat of press strobes while held is compiled in with `define DEBOUNCE_REPEAT_EN.
module btn_debounce_multi #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 131072,
  parameter int CNT_W         = 18,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_btn_state,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic            o_any_press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p [N_CH];
  logic [CNT_W-1:0]       cnt    [N_CH];
  logic [N_CH-1:0]        s_lvl;
  logic [N_CH-1:0]        accept;
  logic [N_CH-1:0]        press_nxt;
  logic [N_CH-1:0]        release_nxt;

  always_comb begin
    s_lvl       = '0;
    accept      = '0;
    release_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      s_lvl[i]       = sync_p[i][SYNC_STAGES-1];
      accept[i]      = (s_lvl[i] != o_btn_state[i]) && (cnt[i] == CNT_MAX);
      release_nxt[i] = accept[i] & ~s_lvl[i];
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt [N_CH];
  logic [N_CH-1:0]  rpt_first;
  logic [N_CH-1:0]  rpt_fire;

  // An accepting edge never repeats: a release on that edge must stop repeats at once.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < N_CH; i++) begin
      rpt_fire[i] = o_btn_state[i] && !accept[i] &&
                    (rpt_cnt[i] == (rpt_first[i] ? RPT_FIRST : RPT_NEXT));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_CH; i++) rpt_cnt[i] <= '0;
      rpt_first <= '1;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (accept[i] || !o_btn_state[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_first[i] <= 1'b1;
        end else if (rpt_fire[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_first[i] <= 1'b0;
        end else begin
          rpt_cnt[i] <= rpt_cnt[i] + RPT_W'(1);
        end
      end
    end
  end

  assign press_nxt = (accept & s_lvl) | rpt_fire;
`else
  assign press_nxt = accept & s_lvl;
`endif

  // Synchroniser shift, stability counter and registered strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_CH; i++) begin
        sync_p[i] <= '0;
        cnt[i]    <= '0;
      end
      o_btn_state <= '0;
      o_press     <= '0;
      o_release   <= '0;
      o_any_press <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (SYNC_STAGES > 1)
          sync_p[i] <= {sync_p[i][SYNC_STAGES-2:0], i_btn[i]};
        if (s_lvl[i] == o_btn_state[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i]         <= '0;
          o_btn_state[i] <= s_lvl[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      o_press     <= press_nxt;
      o_release   <= release_nxt;
      o_any_press <= |press_nxt;
    end
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi; expected strobes are queued with their due cycle and
// compared every cycle by a scoreboard process.
module tb_btn_debounce_multi;
  localparam int N_CH          = 4;
  localparam int STABLE_CYCLES = 8;
  localparam int CNT_W         = 4;
  localparam int SYNC_STAGES   = 2;
  localparam int REPEAT_DELAY  = 20;
  localparam int REPEAT_PERIOD = 10;
  // Input changed before sampling edge cyc+1; strobe lands at edge (cyc+1)+SYNC+STABLE-1.
  localparam int LAT = SYNC_STAGES + STABLE_CYCLES;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic [N_CH-1:0] i_btn = '0;
  logic [N_CH-1:0] o_btn_state;
  logic [N_CH-1:0] o_press;
  logic [N_CH-1:0] o_release;
  logic            o_any_press;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int cyc;
    int ch;
    bit press;
  } ev_t;

  ev_t exp_q[$];
  ev_t keep_q[$];
  int  last_p [N_CH];

  btn_debounce_multi #(
    .N_CH(N_CH), .STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn), .o_btn_state(o_btn_state),
    .o_press(o_press), .o_release(o_release), .o_any_press(o_any_press)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every cycle the strobes must match exactly the events due now.
  always @(negedge i_clk) begin : scoreboard
    logic [N_CH-1:0] ep;
    logic [N_CH-1:0] er;
    ep = '0;
    er = '0;
    keep_q.delete();
    foreach (exp_q[k]) begin
      if (exp_q[k].cyc == cyc) begin
        if (exp_q[k].press) ep[exp_q[k].ch] = 1'b1;
        else                er[exp_q[k].ch] = 1'b1;
      end
      if (exp_q[k].cyc > cyc) keep_q.push_back(exp_q[k]);
    end
    exp_q = keep_q;
    check($sformatf("press@%0d", cyc), o_press, ep);
    check($sformatf("release@%0d", cyc), o_release, er);
    check($sformatf("any_press@%0d", cyc), o_any_press, |ep);
  end

  task automatic drive(input int ch, input bit v);
    int t;
    i_btn[ch] = v;
    t = cyc + LAT;
    if (v) begin
      exp_q.push_back('{cyc: t, ch: ch, press: 1'b1});
      last_p[ch] = t;
    end else begin
`ifdef DEBOUNCE_REPEAT_EN
      for (int r = last_p[ch] + REPEAT_DELAY; r < t; r += REPEAT_PERIOD)
        exp_q.push_back('{cyc: r, ch: ch, press: 1'b1});
`endif
      exp_q.push_back('{cyc: t, ch: ch, press: 1'b0});
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge i_clk);
  endtask

  initial begin
    int t;
    int n;
    for (int i = 0; i < N_CH; i++) last_p[i] = 0;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_state", o_btn_state, 4'b0000);
    check("rst_press", o_press, 4'b0000);
    check("rst_release", o_release, 4'b0000);
    check("rst_any", o_any_press, 1'b0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // T1 clean press on ch0
    drive(0, 1'b1);
    t = cyc + LAT;
    wait_until(t - 1);
    check("t1_state_early", o_btn_state, 4'b0000);
    wait_until(t);
    check("t1_state", o_btn_state, 4'b0001);
    check("t1_press", o_press, 4'b0001);
    @(negedge i_clk);
    check("t1_press_one_cycle", o_press, 4'b0000);
    wait_until(cyc + 3);
    drive(0, 1'b0);
    wait_until(cyc + 12);
    check("t1_released", o_btn_state, 4'b0000);

    // T2 bouncing ch1: 5 high / 2 low, six times, then held
    for (int k = 0; k < 6; k++) begin
      i_btn[1] = 1'b1;
      repeat (5) @(negedge i_clk);
      i_btn[1] = 1'b0;
      repeat (2) @(negedge i_clk);
    end
    check("t2_bounce_state", o_btn_state, 4'b0000);
    drive(1, 1'b1);
    wait_until(cyc + LAT);
    check("t2_state", o_btn_state, 4'b0010);
    wait_until(cyc + 2);
    drive(1, 1'b0);
    wait_until(cyc + 12);

    // T3 release on ch2
    drive(2, 1'b1);
    wait_until(cyc + 12);
    check("t3_pressed", o_btn_state, 4'b0100);
    drive(2, 1'b0);
    t = cyc + LAT;
    wait_until(t - 1);
    check("t3_state_early", o_btn_state, 4'b0100);
    wait_until(t);
    check("t3_release", o_release, 4'b0100);
    check("t3_no_press", o_press, 4'b0000);
    check("t3_state", o_btn_state, 4'b0000);
    wait_until(cyc + 12);

    // T4 simultaneous presses on ch1 and ch3
    drive(1, 1'b1);
    drive(3, 1'b1);
    t = cyc + LAT;
    wait_until(t);
    check("t4_press", o_press, 4'b1010);
    check("t4_any", o_any_press, 1'b1);
    @(negedge i_clk);
    check("t4_press_after", o_press, 4'b0000);
    check("t4_any_after", o_any_press, 1'b0);
    wait_until(cyc + 3);
    drive(1, 1'b0);
    drive(3, 1'b0);
    wait_until(cyc + 12);
    check("t4_released", o_btn_state, 4'b0000);

    // T5 async reset mid-qualification
    drive(0, 1'b1);
    wait_until(cyc + 12);
    check("t5_pre_state", o_btn_state, 4'b0001);
    n = cyc;
    drive(1, 1'b1);
    wait_until(n + 7);
    i_rst = 1'b1;
    #1;
    check("t5_rst_state", o_btn_state, 4'b0000);
    check("t5_rst_press", o_press, 4'b0000);
    check("t5_rst_release", o_release, 4'b0000);
    check("t5_rst_any", o_any_press, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    drive(0, 1'b1);
    drive(1, 1'b1);
    t = cyc + LAT;
    wait_until(t - 1);
    check("t5_requal_early", o_btn_state, 4'b0000);
    wait_until(t);
    check("t5_press", o_press, 4'b0011);
    check("t5_state", o_btn_state, 4'b0011);
    wait_until(cyc + 3);
    drive(0, 1'b0);
    drive(1, 1'b0);
    wait_until(cyc + 12);

    // T6 long hold on ch0 (auto-repeat when compiled in), release before P+50
    drive(0, 1'b1);
    t = cyc + LAT;
    wait_until(t + 35);
    check("t6_held", o_btn_state, 4'b0001);
    drive(0, 1'b0);
    wait_until(t + 60);
    check("t6_released", o_btn_state, 4'b0000);

    wait_until(cyc + 5);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
- Parametrised multi-channel successor to the single-button debouncer.
- Each raw button/switch input is synchronised and debounced symmetrically, for both press and release.
- Produces a clean level per channel plus one-cycle press/release strobes for the game FSM.
- Sits between board pins and game logic (jump/duck/start), all in one clock domain.

Parameters:
- N_CH, 4, number of independent channels (>=1)
- STABLE_CYCLES, 131072, consecutive cycles a new synchronised level must persist before acceptance (>=2)
- CNT_W, 18, stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES-1
- SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
- REPEAT_DELAY, 25000000, cycles from accepted press to first auto-repeat (used only with DEBOUNCE_REPEAT_EN)
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeats (used only with DEBOUNCE_REPEAT_EN)

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset, asynchronous, active-high
- i_btn  input  N_CH  raw asynchronous button levels, 1 = pressed
- o_btn_state  output  N_CH  debounced level per channel
- o_press  output  N_CH  one-cycle strobe on accepted 0->1 (and on auto-repeat when enabled)
- o_release  output  N_CH  one-cycle strobe on accepted 1->0
- o_any_press  output  1  registered OR of the next-cycle o_press bits; asserted in the same cycle as o_press

Behaviour:
- Reset: i_rst high clears immediately, independent of i_clk:
  - all synchroniser flops, counters and repeat counters
  - o_btn_state, o_press, o_release, o_any_press all go to 0
- Reset mid-count discards partial progress. After release of i_rst, a held button requires a full qualification; it then produces o_press.
- Per channel, all registered:
  - Synchroniser: SYNC_STAGES flops; s = last stage.
  - s == o_btn_state[i]: counter cleared to 0, strobes 0.
  - s != o_btn_state[i] and cnt < STABLE_CYCLES-1: cnt increments.
  - s != o_btn_state[i] and cnt == STABLE_CYCLES-1, on that edge:
    - o_btn_state[i] <= s
    - cnt <= 0
    - o_press[i] <= s, o_release[i] <= ~s, each for exactly one cycle.
- Latency: count the first edge that samples the new raw level as edge 0. o_btn_state and its strobe update at edge SYNC_STAGES+STABLE_CYCLES-1 (9 for SYNC_STAGES=2, STABLE_CYCLES=8).
- Bounce: any single-cycle return of s to the current state restarts qualification from 0. No strobe is ever emitted without a state change (except repeat).
- Counter never exceeds STABLE_CYCLES-1; no wrap-around possible.
- Channels are fully independent:
  - simultaneous events on several channels strobe in the same cycle;
  - o_press and o_release are never both set on one channel.
- o_any_press is registered with the same timing as o_press (OR of next-cycle o_press bits).

Optional Feature:
- Macro: DEBOUNCE_REPEAT_EN.
- Defined: per-channel repeat counter (width sized to max(REPEAT_DELAY, REPEAT_PERIOD)).
  - Counter cleared on the accepted press.
  - While o_btn_state[i]=1, o_press[i] pulses again REPEAT_DELAY cycles after the press strobe, then every REPEAT_PERIOD cycles.
  - Accepted release or i_rst stops repeats immediately and clears the counter.
  - o_any_press includes repeat strobes.
- Undefined: no repeat logic is synthesised; REPEAT_* parameters are ignored; o_press fires only on accepted 0->1.

Test Plan:
Bench parameters: N_CH=4, STABLE_CYCLES=8, SYNC_STAGES=2, CNT_W=4.
1. Clean press: i_btn[0] 0->1 held -> o_btn_state[0] and o_press[0] rise at edge 9; o_press[0] high exactly 1 cycle; channels 1-3 and o_release stay 0.
2. Bounce: i_btn[1] toggles high 5 cycles / low 2 cycles, repeated 6 times, then held high -> no strobe during bouncing; o_press[1] at edge 9 after the final rising sample.
3. Release: from o_btn_state[2]=1, i_btn[2] 1->0 held -> o_release[2] 1-cycle pulse and o_btn_state[2]=0 at edge 9; o_press[2] stays 0.
4. Simultaneous: i_btn[1] and i_btn[3] rise on the same edge -> o_press=4'b1010 in one cycle; o_any_press=1 for that same single cycle.
5. Async reset: assert i_rst between clock edges at cnt=5 with o_btn_state=4'b0001 -> all outputs 0 before the next edge. Release with i_btn[0] still high -> o_press[0] again 9 edges after the first post-reset sampling edge.
6. Repeat (REPEAT_DELAY=20, REPEAT_PERIOD=10): hold i_btn[0].
   - With DEBOUNCE_REPEAT_EN: o_press[0] pulses at press edge P, P+20, P+30, P+40; release stops further pulses.
   - Without the macro: a single pulse at P only.
